// File: rtl/rr_arb3.sv
// Three-requester round-robin arbiter for a shared resource with a bounded grant window.
// One grant at a time; each grant ends with a done pulse, plus a timeout pulse if the resource never answered.
module rr_arb3 #(
  parameter int TMO = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       mem_ready,
  output logic [1:0] sel,
  output logic [2:0] gnt,
  output logic       mem_valid,
  output logic [2:0] done,
  output logic       timeout,
  output logic       busy
);

  localparam int CW = (TMO > 1) ? $clog2(TMO) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TMO - 1);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

  logic          state;
  logic [1:0]    ptr;
  logic [CW-1:0] cnt;
  logic [2:0]    elig;
  logic [1:0]    cand0, cand1, cand2;
  logic [1:0]    win;
  logic          win_vld;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic bit_at(input logic [2:0] v, input logic [1:0] i);
    case (i)
      2'd0:    return v[0];
      2'd1:    return v[1];
      2'd2:    return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // A requester whose done pulse is visible this cycle cannot win again until it re-raises.
  always_comb begin
    elig    = req & ~done;
    win_vld = |elig;
    cand0   = ptr;
    cand1   = inc3(cand0);
    cand2   = inc3(cand1);
    win     = cand2;
    if (bit_at(elig, cand1)) win = cand1;
    if (bit_at(elig, cand0)) win = cand0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      gnt     <= 3'b000;
      sel     <= 2'b00;
      done    <= 3'b000;
      timeout <= 1'b0;
      ptr     <= 2'd0;
      cnt     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done    <= 3'b000;
          timeout <= 1'b0;
          if (win_vld) begin
            state <= ST_GRANT;
            gnt   <= 3'b001 << win;
            sel   <= win;
            cnt   <= '0;
          end
        end
        default: begin
          // Completion beats the timeout when both land on the same edge.
          if (mem_ready || cnt == CNT_LAST) begin
            state   <= ST_IDLE;
            gnt     <= 3'b000;
            done    <= gnt;
            timeout <= ~mem_ready;
            ptr     <= inc3(sel);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  assign busy      = (state == ST_GRANT);
  assign mem_valid = (state == ST_GRANT);

endmodule

// File: tb/tb_rr_arb3.sv
// Directed bench for rr_arb3 (TMO=4): a transaction-level model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_rr_arb3;

  localparam int TMO = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] req = 3'b000;
  logic       mem_ready = 1'b0;
  logic [1:0] sel;
  logic [2:0] gnt;
  logic       mem_valid;
  logic [2:0] done;
  logic       timeout;
  logic       busy;

  int errors = 0;
  int checks = 0;

  rr_arb3 #(.TMO(TMO)) dut (
    .clk(clk), .rst(rst), .req(req), .mem_ready(mem_ready),
    .sel(sel), .gnt(gnt), .mem_valid(mem_valid), .done(done),
    .timeout(timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: who owns the resource, how many grant cycles it has used, who is next in line.
  bit       m_on = 1'b0;
  bit       m_busy;
  int       m_owner;
  int       m_used;
  int       m_next;
  int       m_sel;
  bit [2:0] m_done;
  bit       m_to;

  function automatic int pick(input bit [2:0] r, input int start);
    for (int k = 0; k < 3; k++) begin
      if (r[(start + k) % 3]) return (start + k) % 3;
    end
    return -1;
  endfunction

  always @(posedge clk) begin
    int w;
    if (rst) begin
      m_on   <= 1'b1;
      m_busy <= 1'b0;
      m_owner <= 0;
      m_used <= 0;
      m_next <= 0;
      m_sel  <= 0;
      m_done <= 3'b000;
      m_to   <= 1'b0;
    end else if (m_on) begin
      if (!m_busy) begin
        m_done <= 3'b000;
        m_to   <= 1'b0;
        w = pick(req & ~m_done, m_next);
        if (w >= 0) begin
          m_busy  <= 1'b1;
          m_owner <= w;
          m_sel   <= w;
          m_used  <= 1;
        end
      end else if (mem_ready || m_used == TMO) begin
        m_busy <= 1'b0;
        m_done <= 3'b001 << m_owner;
        m_to   <= !mem_ready;
        m_next <= (m_owner + 1) % 3;
      end else begin
        m_used <= m_used + 1;
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_on) begin
      check("model_gnt", 8'(gnt), m_busy ? 8'(3'b001 << m_owner) : 8'd0);
      check("model_sel", 8'(sel), 8'(m_sel));
      check("model_mem_valid", 8'(mem_valid), 8'(m_busy));
      check("model_busy", 8'(busy), 8'(m_busy));
      check("model_done", 8'(done), 8'(m_done));
      check("model_timeout", 8'(timeout), 8'(m_to));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_gnt"}, 8'(gnt), 8'd0);
    check({tag, "_sel"}, 8'(sel), 8'd0);
    check({tag, "_mem_valid"}, 8'(mem_valid), 8'd0);
    check({tag, "_busy"}, 8'(busy), 8'd0);
    check({tag, "_done"}, 8'(done), 8'd0);
    check({tag, "_timeout"}, 8'(timeout), 8'd0);
  endtask

  logic [2:0] fair_exp [5];

  initial begin
    fair_exp[0] = 3'b001; fair_exp[1] = 3'b010; fair_exp[2] = 3'b100;
    fair_exp[3] = 3'b001; fair_exp[4] = 3'b010;

    // Reset, then a single request completing in its second grant cycle.
    tick(); tick();
    check_reset_vals("reset");
    rst = 1'b0;
    req = 3'b001;
    tick();
    check("single_gnt1", 8'(gnt), 8'h01);
    check("single_sel1", 8'(sel), 8'h00);
    check("single_mv1", 8'(mem_valid), 8'h01);
    tick();
    check("single_gnt2", 8'(gnt), 8'h01);
    mem_ready = 1'b1;
    tick();
    check("single_done", 8'(done), 8'h01);
    check("single_gnt_clr", 8'(gnt), 8'h00);
    req = 3'b000; mem_ready = 1'b0;
    tick();
    check("single_done_off", 8'(done), 8'h00);

    // Fairness from reset with all three requesting.
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("fair_gnt", 8'(gnt), 8'(fair_exp[i]));
      tick();
      check("fair_idle", 8'(busy), 8'h00);
      if (i == 4) req = 3'b000;
    end
    tick();

    // Pointer wrap: grant to 2, then 101 goes to 0, then 101 goes to 2.
    req = 3'b100;
    tick();
    check("wrap_g2", 8'(gnt), 8'h04);
    tick(); req = 3'b000; tick();
    req = 3'b101;
    tick();
    check("wrap_g0", 8'(gnt), 8'h01);
    check("wrap_sel0", 8'(sel), 8'h00);
    tick(); req = 3'b000; tick();
    req = 3'b101;
    tick();
    check("wrap_g2b", 8'(gnt), 8'h04);
    check("wrap_sel2", 8'(sel), 8'h02);
    tick(); req = 3'b000; tick();

    // Timeout: resource never answers.
    mem_ready = 1'b0;
    req = 3'b010;
    for (int i = 0; i < TMO; i++) begin
      tick();
      check("tmo_busy", 8'(busy), 8'h01);
      check("tmo_sel", 8'(sel), 8'h01);
    end
    tick();
    check("tmo_pulse", 8'(timeout), 8'h01);
    check("tmo_done", 8'(done), 8'h02);
    check("tmo_idle", 8'(busy), 8'h00);
    req = 3'b000;
    tick();
    check("tmo_pulse_off", 8'(timeout), 8'h00);
    check("tmo_sel_hold", 8'(sel), 8'h01);

    // Completion in the last allowed grant cycle beats the timeout.
    req = 3'b001;
    for (int i = 0; i < TMO; i++) tick();
    check("race_busy", 8'(busy), 8'h01);
    mem_ready = 1'b1;
    tick();
    check("race_done", 8'(done), 8'h01);
    check("race_timeout", 8'(timeout), 8'h00);
    req = 3'b000; mem_ready = 1'b0;
    tick();

    // Reset in the second grant cycle.
    req = 3'b010;
    tick(); tick();
    check("rst_mid_busy", 8'(busy), 8'h01);
    rst = 1'b1;
    tick();
    check_reset_vals("rst_mid");
    rst = 1'b0; req = 3'b000;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_mid_nodone", 8'(done), 8'h00);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rr_arb3.md
RR_ARB3 -- requirements
Module: rr_arb3

Interface
REQ-001 SHALL have parameter TMO, default 16, giving the maximum number of cycles spent in GRANT before abort (legal range 1..255).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port req, input, 3, per-requester request; each bit is held high until the matching done pulse.
REQ-005 SHALL have port mem_ready, input, 1, shared-resource completion, sampled only in GRANT.
REQ-006 SHALL have port sel, output, 2, select for the shared 3-way data mux (2'b00/01/10).
REQ-007 SHALL have port gnt, output, 3, one-hot grant, registered.
REQ-008 SHALL have port mem_valid, output, 1, request to the shared resource, registered.
REQ-009 SHALL have port done, output, 3, one-cycle completion pulse to the granted requester.
REQ-010 SHALL have port timeout, output, 1, one-cycle abort pulse.
REQ-011 SHALL have port busy, output, 1, high while in GRANT.

Function
REQ-012 SHALL implement a two-state FSM, IDLE and GRANT, with mem_valid = busy = (state==GRANT).
REQ-013 SHALL in IDLE, when any unmasked req bit is sampled high, select the winner round-robin starting at pointer ptr (search ptr, ptr+1, ptr+2 mod 3) and enter GRANT at that edge.
REQ-014 SHALL present gnt, sel and mem_valid for the winner in the cycle after the sampling edge (1-cycle latency).
REQ-015 SHALL mask req[k] from arbitration in any cycle where done[k]=1.
REQ-016 SHALL keep sel and gnt stable for the whole of GRANT; dropping req mid-grant SHALL NOT affect the transaction.
REQ-017 SHALL, on an edge in GRANT with mem_ready=1, go to IDLE, clear gnt, pulse done[idx] for exactly one cycle, and set ptr = idx+1 mod 3 (2 wraps to 0).
REQ-018 SHALL keep a cycle counter cnt cleared on entry to GRANT and incremented each GRANT cycle; the width SHALL hold TMO-1.
REQ-019 SHALL, on an edge in GRANT with mem_ready=0 and cnt==TMO-1, abort: go to IDLE, pulse timeout and done[idx] together for one cycle, and advance ptr as in REQ-017.
REQ-020 SHALL let mem_ready=1 take priority over timeout on the same edge (normal completion, timeout=0).
REQ-021 SHALL always spend at least one IDLE cycle between consecutive grants (no back-to-back GRANT).
REQ-022 SHALL hold the last sel value in IDLE and SHALL never drive sel=2'b11.
REQ-023 SHALL keep gnt zero or one-hot at all times, with gnt nonzero iff busy=1.

Reset
REQ-024 SHALL, on an edge with rst=1, set state=IDLE, gnt=000, sel=00, mem_valid=0, done=000, timeout=0, ptr=0 and cnt=0.
REQ-025 SHALL let rst win over every other event; reset during GRANT SHALL abort the transaction with no done or timeout pulse.

Verification (TMO=4)
REQ-026 SHALL cover single request: after reset, req=001 at edge 0, then mem_ready=1 in the second GRANT cycle -> gnt=001/sel=00/mem_valid=1 for 2 cycles, then done=001 for 1 cycle with gnt=000.
REQ-027 SHALL cover fairness: req=111 held (each requester re-raises after its done), mem_ready=1 -> grant order 0,1,2,0,1, with one IDLE cycle between grants.
REQ-028 SHALL cover pointer wrap: after a grant to 2, req=101 -> grant to 0 (sel=00); then req=101 again -> grant to 2 (sel=10).
REQ-029 SHALL cover timeout: req=010, mem_ready=0 -> 4 GRANT cycles with sel=01, then timeout=1 and done=010 together for one cycle, sel remaining 01 in IDLE.
REQ-030 SHALL cover completion versus timeout: mem_ready=1 in the 4th GRANT cycle -> done pulse, timeout=0.
REQ-031 SHALL cover reset mid-grant: rst=1 in the 2nd GRANT cycle -> all outputs at reset values next cycle, no done pulse ever issued.
